// File: rtl/sobel_window_ctrl_if.sv
// Bundle between the Sobel window sequencer and its surroundings (pixel source, filter, sink).
// Handshakes (pix_*, out_*): a beat transfers on a rising edge where valid && ready; valid never depends on ready.
interface sobel_window_ctrl_if;
  logic         start;
  logic         busy;
  logic         done;
  logic [7:0]   pix_in;
  logic         pix_valid;
  logic         pix_ready;
  logic [199:0] win_out;
  logic [7:0]   filt_in;
  logic [7:0]   out_pixel;
  logic         out_valid;
  logic         out_ready;
  logic         out_last;

  modport slave (
    input  start, pix_in, pix_valid, filt_in, out_ready,
    output busy, done, pix_ready, win_out, out_pixel, out_valid, out_last
  );

  modport master (
    output start, pix_in, pix_valid, filt_in, out_ready,
    input  busy, done, pix_ready, win_out, out_pixel, out_valid, out_last
  );
endinterface

// File: rtl/sobel_window_ctrl.sv
// Sequencer for a 5x5 Sobel stage: four line buffers feed a 5x5 window, and the filter
// result is captured into a valid/ready output register. Only fully populated windows are emitted.
module sobel_window_ctrl #(
  parameter int IMG_WIDTH  = 64,
  parameter int IMG_HEIGHT = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  sobel_window_ctrl_if.slave  bus,
  output logic [1:0]          state_o
);
  localparam int XW = $clog2(IMG_WIDTH);
  localparam int YW = $clog2(IMG_HEIGHT);
  localparam logic [XW-1:0] X_LAST = XW'(IMG_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_HEIGHT - 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_STREAM = 2'd1;
  localparam logic [1:0] ST_FLUSH  = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic          win_valid_q, win_valid_d;
  logic          win_last_q, win_last_d;
  logic          out_valid_q, out_valid_d;
  logic          out_last_q, out_last_d;
  logic [7:0]    out_pixel_q, out_pixel_d;

  // lb_q[0] holds line y-4 (oldest) ... lb_q[3] holds line y-1.
  logic [7:0] lb_q [4][IMG_WIDTH];
  logic [7:0] win_q [5][5];
  logic [7:0] col [5];

  logic stall, accept, at_last_x, at_last_y, eligible;

  assign stall         = out_valid_q && !bus.out_ready;
  assign bus.pix_ready = (state_q == ST_STREAM) && !stall;
  assign accept        = bus.pix_valid && bus.pix_ready;
  assign at_last_x     = (x_q == X_LAST);
  assign at_last_y     = (y_q == Y_LAST);
  assign eligible      = (x_q >= XW'(4)) && (y_q >= YW'(4));

  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.done      = (state_q == ST_DONE);
  assign bus.out_valid = out_valid_q;
  assign bus.out_pixel = out_pixel_q;
  assign bus.out_last  = out_last_q;
  assign state_o       = state_q;

  always_comb begin
    for (int r = 0; r < 4; r++) col[r] = lb_q[r][x_q];
    col[4] = bus.pix_in;
  end

  always_comb begin
    bus.win_out = '0;
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++)
        bus.win_out[40*r + 8*c +: 8] = win_q[r][c];
  end

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    win_valid_d = win_valid_q;
    win_last_d  = win_last_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_pixel_d = out_pixel_q;

    if (!stall) begin
      out_valid_d = win_valid_q;
      out_pixel_d = bus.filt_in;
      out_last_d  = win_valid_q && win_last_q;
      win_valid_d = 1'b0;
    end

    // An accept implies no stall, so the old window was consumed above in the same cycle.
    if (accept) begin
      win_valid_d = eligible;
      win_last_d  = at_last_x && at_last_y;
      if (at_last_x) begin
        x_d = '0;
        y_d = at_last_y ? '0 : y_q + YW'(1);
      end else begin
        x_d = x_q + XW'(1);
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_STREAM;
          x_d     = '0;
          y_d     = '0;
        end
      end
      ST_STREAM: if (accept && at_last_x && at_last_y) state_d = ST_FLUSH;
      ST_FLUSH:  if (out_valid_q && bus.out_ready && out_last_q) state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      x_q         <= '0;
      y_q         <= '0;
      win_valid_q <= 1'b0;
      win_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_pixel_q <= '0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      win_valid_q <= win_valid_d;
      win_last_q  <= win_last_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_pixel_q <= out_pixel_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < 5; r++)
        for (int c = 0; c < 5; c++)
          win_q[r][c] <= '0;
    end else if (accept) begin
      for (int r = 0; r < 5; r++) begin
        for (int c = 0; c < 4; c++) win_q[r][c] <= win_q[r][c+1];
        win_q[r][4] <= col[r];
      end
    end
  end

  // Line storage is not reset; rows older than the frame start never reach an emitted window.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int i = 0; i < 3; i++) lb_q[i][x_q] <= lb_q[i+1][x_q];
      lb_q[3][x_q] <= bus.pix_in;
    end
  end
endmodule

// File: tb/tb_sobel_window_ctrl.sv
// Self-checking bench for sobel_window_ctrl on an 8x6 frame with a behavioural filter attached.
module tb_sobel_window_ctrl;
  localparam int W = 8;
  localparam int H = 6;

  logic       clk;
  logic       rst_n;
  logic [1:0] state_dbg;

  sobel_window_ctrl_if bus();

  sobel_window_ctrl #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .state_o (state_dbg)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int done_cnt = 0;
  int last_hs_cyc = -100;
  int fmode = 0;       // 0: horizontal edge filter, 1: position-weighted hash
  int ready_mode = 0;  // 0: always ready, 1: ready 1 of 3 cycles, 2: random
  int img [H][W];
  logic [7:0] exp_q [$];

  logic       prev_stall = 1'b0;
  logic [7:0] prev_pix   = '0;
  logic       prev_last  = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [7:0] filt_fn(input logic [199:0] w, input int mode);
    int s;
    int p;
    s = 0;
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++) begin
        p = int'(w[40*r + 8*c +: 8]);
        if (mode == 0) begin
          if (c == 4) s += p;
          else if (c == 0) s -= p;
        end else begin
          s += p * (r*5 + c + 1);
        end
      end
    if (mode == 0) begin
      if (s < 0) s = -s;
      s = s >>> 1;
      if (s > 255) s = 255;
    end
    return s[7:0];
  endfunction

  function automatic logic [7:0] ref_out(input int x, input int y);
    logic [199:0] w;
    w = '0;
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++)
        w[40*r + 8*c +: 8] = 8'(img[y-4+r][x-4+c]);
    return filt_fn(w, fmode);
  endfunction

  always_comb bus.filt_in = filt_fn(bus.win_out, fmode);

  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        1:       bus.out_ready = (cyc % 3 == 0);
        2:       bus.out_ready = ($urandom_range(1) == 1);
        default: bus.out_ready = 1'b1;
      endcase
    end
  end

  // Output monitor and scoreboard
  always @(negedge clk) begin
    cyc++;
    if (rst_n) begin
      if (bus.done) begin
        done_cnt++;
        chk("done_delay", cyc - last_hs_cyc, 1);
        chk("busy_at_done", bus.busy, 1);
      end
      if (bus.out_last) chk("last_has_valid", bus.out_valid, 1);
      if (prev_stall)
        chk("stall_hold", {bus.out_valid, bus.out_pixel, bus.out_last}, {1'b1, prev_pix, prev_last});
      if (bus.out_valid && !bus.out_ready) chk("pix_ready_stall", bus.pix_ready, 0);
      if (bus.out_valid && bus.out_ready) begin
        chk("sb_has_entry", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          chk("out_pixel", bus.out_pixel, exp_q.pop_front());
          chk("out_last", bus.out_last, exp_q.size() == 0);
        end
        if (bus.out_last) last_hs_cyc = cyc;
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_pix   = bus.out_pixel;
      prev_last  = bus.out_last;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic fill_img(input int mode);
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        case (mode)
          0:       img[y][x] = 10 * x;
          1:       img[y][x] = 77;
          default: img[y][x] = int'($urandom_range(255));
        endcase
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    @(negedge clk);
    chk("busy_after_start", bus.busy, 1);
    @(posedge clk);
    #1;
  endtask

  // Called at posedge+1; returns at posedge+1 with pix_valid low.
  task automatic send_pixels(input int gap_pct, input int glitch_at, input int count);
    int   i = 0;
    int   guard = 0;
    logic glitched = 1'b0;
    logic acc;
    while (i < count && guard < 5000) begin
      bus.pix_valid = (int'($urandom_range(99)) >= gap_pct);
      bus.pix_in    = 8'(img[i / W][i % W]);
      if (i == glitch_at && !glitched) begin
        bus.start = 1'b1;
        glitched  = 1'b1;
      end
      @(negedge clk);
      acc = bus.pix_valid && bus.pix_ready;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      if (acc) i++;
      guard++;
    end
    bus.pix_valid = 1'b0;
    chk("pixels_accepted", i, count);
  endtask

  task automatic run_frame(input int img_mode, input int f_mode, input int gap_pct,
                           input int r_mode, input int glitch_at);
    int done_before;
    int g = 0;
    fill_img(img_mode);
    fmode = f_mode;
    for (int y = 4; y < H; y++)
      for (int x = 4; x < W; x++)
        exp_q.push_back(ref_out(x, y));
    done_before = done_cnt;
    ready_mode  = r_mode;
    pulse_start();
    send_pixels(gap_pct, glitch_at, W * H);
    while (done_cnt == done_before && g < 500) begin
      @(negedge clk);
      g++;
    end
    chk("done_seen", done_cnt - done_before, 1);
    repeat (5) @(negedge clk);
    chk("done_once", done_cnt - done_before, 1);
    chk("sb_drained", exp_q.size(), 0);
    chk("busy_idle", bus.busy, 0);
    chk("state_idle", state_dbg, 0);
    exp_q.delete();
    ready_mode = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_done"}, bus.done, 0);
    chk({tag, "_pix_ready"}, bus.pix_ready, 0);
    chk({tag, "_out_valid"}, bus.out_valid, 0);
    chk({tag, "_out_last"}, bus.out_last, 0);
    chk({tag, "_out_pixel"}, bus.out_pixel, 0);
    chk({tag, "_win_zero"}, bus.win_out == '0, 1);
    chk({tag, "_state"}, state_dbg, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.pix_valid = 1'b0;
    bus.pix_in    = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_frame(0, 0, 0, 0, -1);    // ramp -> 8 x 100
    run_frame(1, 0, 0, 0, -1);    // constant -> 8 x 0
    run_frame(0, 0, 0, 1, -1);    // ramp with 1-of-3 ready
    run_frame(0, 0, 50, 0, -1);   // ramp with 50% input gaps

    // Abort a ramp frame after 20 pixels; nothing from it may appear later.
    fill_img(0);
    fmode = 0;
    pulse_start();
    send_pixels(0, -1, 20);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("midrst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_frame(0, 0, 0, 0, -1);

    run_frame(0, 0, 0, 0, 10);    // start pulse while busy is ignored
    run_frame(2, 1, 30, 2, -1);   // random image, hash filter, gaps + random ready
    run_frame(2, 1, 0, 0, -1);    // random image, hash filter, full rate

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
